// File: rtl/karplus_pkg.sv
// Shared definitions for the Karplus-Strong pluck sequencer.
// Holds the Avalon register map, the sequencer state encoding and the
// noise LFSR constants plus its one-step update function.
package karplus_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_NOTE   = 3'd2;
    localparam logic [2:0] ADDR_DIV    = 3'd3;
    localparam logic [2:0] ADDR_SEED   = 3'd4;
    localparam logic [2:0] ADDR_DUR    = 3'd5;
    localparam logic [2:0] ADDR_AMP    = 3'd6;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_LO,
        ST_FILL_HI,
        ST_PLAY,
        ST_MUTE_LO,
        ST_MUTE_HI,
        ST_DONE
    } state_t;

    // One Galois step: shift right, fold the taps in when a 1 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur,
                                              input logic [15:0] poly);
        return cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
    endfunction

endpackage

// File: rtl/karplus_pluck_sequencer_lfsr16.sv
// 16-bit Galois LFSR used as the noise source for the delay-line fill.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (to RESET_VALUE)
//   load, seed  - load seed on the next edge (has priority over step)
//   step        - advance one Galois step on the next edge
//   state       - current register value
//   state_next  - value the register takes on the next edge
module lfsr16 #(
    parameter logic [15:0] POLY        = karplus_pkg::LFSR_POLY,
    parameter logic [15:0] RESET_VALUE = karplus_pkg::LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state,
    output logic [15:0] state_next
);
    import karplus_pkg::*;

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = seed;
        end else if (step) begin
            state_next = lfsr_next(state, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_VALUE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/karplus_pluck_sequencer.sv
// Avalon-MM slave that sequences one pluck of the Karplus-Strong core:
// fill the delay line with LFSR noise, let it play for DUR cycles, then
// mute by filling with zeros and flag done (optionally interrupting).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   address, chipselect, write,
//   writedata, readdata        - Avalon slave, zero-wait-state reads
//   irq                        - done & irq_en
//   noise, noise_en,
//   noise_pulse, sel_nota,
//   div_freq                   - registered drive to the synth core
module karplus_pluck_sequencer #(
    parameter int unsigned DEPTH      = 500,
    parameter int unsigned PULSE_HALF = 2,
    parameter logic [15:0] LFSR_POLY  = karplus_pkg::LFSR_POLY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [15:0] noise,
    output logic        noise_en,
    output logic        noise_pulse,
    output logic [9:0]  sel_nota,
    output logic [31:0] div_freq
);
    import karplus_pkg::*;

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned PH_W   = $clog2(PULSE_HALF + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PULSE_HALF - 1);
    localparam logic [9:0]        NOTE_MAX  = 10'(DEPTH - 1);

    state_t state, state_nxt;

    logic [PH_W-1:0]   ph_cnt, ph_nxt;
    logic [FILL_W-1:0] fill_cnt, fill_nxt;
    logic [31:0]       dur_cnt, dur_nxt;

    // Software-visible configuration and the copies latched at start.
    logic [9:0]  note_cfg, note_w;
    logic [31:0] div_cfg, div_w;
    logic [15:0] seed_cfg;
    logic [31:0] dur_cfg, dur_w;
    logic [3:0]  amp_cfg, amp_w;
    logic        done, irq_en;

    logic [15:0] lfsr_q, lfsr_d, seed_eff;
    logic        lfsr_load, lfsr_step;

    logic [15:0] noise_nxt;
    logic        pulse_nxt, en_nxt;
    logic [9:0]  sel_nxt;
    logic [31:0] div_nxt;
    logic [3:0]  amp_d;

    logic wr_en, ctrl_wr, status_wr, start_ok, abort_req, busy;
    logic ph_done, fill_last;

    assign wr_en     = chipselect & write;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    assign abort_req = ctrl_wr & writedata[1];
    assign start_ok  = ctrl_wr & writedata[0] & ~writedata[1] & (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign seed_eff  = (seed_cfg == 16'd0) ? LFSR_DEFAULT_SEED : seed_cfg;
    assign ph_done   = (ph_cnt == PH_LAST);
    assign fill_last = (fill_cnt == FILL_LAST);
    assign irq       = done & irq_en;

    lfsr16 #(
        .POLY        (LFSR_POLY),
        .RESET_VALUE (LFSR_DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (lfsr_load),
        .step       (lfsr_step),
        .seed       (seed_eff),
        .state      (lfsr_q),
        .state_next (lfsr_d)
    );

    // Next state, counters and next values of the registered core outputs.
    // Outputs are derived from state_nxt so they line up with the state.
    always_comb begin
        state_nxt = state;
        ph_nxt    = '0;
        fill_nxt  = fill_cnt;
        dur_nxt   = dur_cnt;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_FILL_LO;
                    fill_nxt  = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_FILL_LO, ST_MUTE_LO: begin
                if (ph_done) begin
                    state_nxt = (state == ST_FILL_LO) ? ST_FILL_HI : ST_MUTE_HI;
                end else begin
                    ph_nxt = ph_cnt + 1'b1;
                end
            end
            ST_FILL_HI: begin
                if (ph_done) begin
                    lfsr_step = 1'b1;
                    fill_nxt  = fill_cnt + 1'b1;
                    state_nxt = fill_last ? ST_PLAY : ST_FILL_LO;
                    // First PLAY cycle counts as 1 so PLAY lasts max(dur,1).
                    dur_nxt   = 32'd1;
                end else begin
                    ph_nxt = ph_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                if (dur_cnt >= dur_w) begin
                    state_nxt = ST_MUTE_LO;
                    fill_nxt  = '0;
                end else begin
                    dur_nxt = dur_cnt + 32'd1;
                end
            end
            ST_MUTE_HI: begin
                if (ph_done) begin
                    fill_nxt  = fill_cnt + 1'b1;
                    state_nxt = fill_last ? ST_DONE : ST_MUTE_LO;
                end else begin
                    ph_nxt = ph_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort_req && (state == ST_FILL_LO || state == ST_FILL_HI || state == ST_PLAY)) begin
            state_nxt = ST_MUTE_LO;
            fill_nxt  = '0;
            ph_nxt    = '0;
            lfsr_step = 1'b0;
        end

        amp_d     = start_ok ? amp_cfg : amp_w;
        noise_nxt = '0;
        pulse_nxt = 1'b0;
        en_nxt    = 1'b1;
        sel_nxt   = sel_nota;
        div_nxt   = div_freq;
        case (state_nxt)
            ST_FILL_LO: noise_nxt = lfsr_d >> amp_d;
            ST_FILL_HI: begin
                noise_nxt = lfsr_d >> amp_d;
                pulse_nxt = 1'b1;
            end
            ST_MUTE_HI: pulse_nxt = 1'b1;
            ST_PLAY: begin
                en_nxt  = 1'b0;
                sel_nxt = ({22'd0, note_w} >= DEPTH) ? NOTE_MAX : note_w;
                div_nxt = div_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            fill_cnt    <= '0;
            dur_cnt     <= '0;
            noise       <= '0;
            noise_en    <= 1'b1;
            noise_pulse <= 1'b0;
            sel_nota    <= NOTE_MAX;
            div_freq    <= '0;
        end else begin
            state       <= state_nxt;
            ph_cnt      <= ph_nxt;
            fill_cnt    <= fill_nxt;
            dur_cnt     <= dur_nxt;
            noise       <= noise_nxt;
            noise_en    <= en_nxt;
            noise_pulse <= pulse_nxt;
            sel_nota    <= sel_nxt;
            div_freq    <= div_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_cfg <= '0;
            div_cfg  <= '0;
            seed_cfg <= '0;
            dur_cfg  <= '0;
            amp_cfg  <= '0;
            note_w   <= '0;
            div_w    <= '0;
            dur_w    <= '0;
            amp_w    <= '0;
            done     <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_STATUS: if (writedata[2]) irq_en <= 1'b1;
                    ADDR_NOTE:   note_cfg <= writedata[9:0];
                    ADDR_DIV:    div_cfg  <= writedata;
                    ADDR_SEED:   seed_cfg <= writedata[15:0];
                    ADDR_DUR:    dur_cfg  <= writedata;
                    ADDR_AMP:    amp_cfg  <= writedata[3:0];
                    default: ;
                endcase
            end
            // Completion beats a software clear landing on the same edge.
            if (state == ST_DONE) begin
                done <= 1'b1;
            end else if (status_wr && writedata[1]) begin
                done <= 1'b0;
            end
            if (start_ok) begin
                note_w <= note_cfg;
                div_w  <= div_cfg;
                dur_w  <= dur_cfg;
                amp_w  <= amp_cfg;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: readdata = {29'd0, irq_en, done, busy};
            ADDR_NOTE:   readdata = {22'd0, note_cfg};
            ADDR_DIV:    readdata = div_cfg;
            ADDR_SEED:   readdata = {16'd0, seed_cfg};
            ADDR_DUR:    readdata = dur_cfg;
            ADDR_AMP:    readdata = {28'd0, amp_cfg};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_karplus_pluck_sequencer.sv
// Scoreboard bench for karplus_pluck_sequencer (DEPTH=8, PULSE_HALF=2).
// Stimulus pushes the expected event stream of each pluck (fill pulses,
// play window, mute pulses, done interrupt); a monitor pops and compares
// whenever the core-facing outputs show an event.
module tb_karplus_pluck_sequencer;

    localparam int DEPTH = 8;
    localparam int PH    = 2;
    localparam int EV_PULSE = 0;
    localparam int EV_PLAY  = 1;
    localparam int EV_DONE  = 2;
    localparam logic [31:0] DONT_CARE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [15:0] noise;
    logic        noise_en;
    logic        noise_pulse;
    logic [9:0]  sel_nota;
    logic [31:0] div_freq;

    always #5 clk = ~clk;

    karplus_pluck_sequencer #(
        .DEPTH      (DEPTH),
        .PULSE_HALF (PH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq),
        .noise       (noise),
        .noise_en    (noise_en),
        .noise_pulse (noise_pulse),
        .sel_nota    (sel_nota),
        .div_freq    (div_freq)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        bit          first;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic [31:0] cyc = 0;

    // Reference configuration and interrupt-enable state.
    logic        irq_en_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input int kind, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input bit first);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.first = first;
        return e;
    endfunction

    // Noise generator as described: halve, and fold in the taps when odd.
    function automatic logic [15:0] ref_lfsr(input logic [15:0] x);
        int unsigned v;
        v = int'(x) / 2;
        if (x % 2 == 1) v = v ^ 32'hB400;
        return v[15:0];
    endfunction

    task automatic push_pluck(input logic [15:0] seed, input logic [3:0] amp,
                              input logic [9:0] note, input logic [31:0] div,
                              input logic [31:0] dur, input bit len_known);
        logic [15:0] l;
        logic [31:0] len;
        l = (seed == 16'd0) ? 16'hACE1 : seed;
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(mk(EV_PULSE, {16'd0, l >> amp}, 0, 0, i == 0));
            l = ref_lfsr(l);
        end
        len = len_known ? ((dur == 0) ? 32'd1 : dur) : DONT_CARE;
        q.push_back(mk(EV_PLAY, (note >= DEPTH) ? DEPTH - 1 : {22'd0, note}, div, len, 1'b0));
        for (int i = 0; i < DEPTH; i++) q.push_back(mk(EV_PULSE, 0, 0, 0, i == 0));
        if (irq_en_m) q.push_back(mk(EV_DONE, 0, 0, 0, 1'b0));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b0; address = a;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic pluck(input logic [15:0] seed, input logic [3:0] amp, input logic [9:0] note,
                         input logic [31:0] div, input logic [31:0] dur, input bit len_known);
        push_pluck(seed, amp, note, div, dur, len_known);
        wr(3'd4, {$urandom} << 16 | {16'd0, seed});
        wr(3'd6, {28'd0, amp});
        wr(3'd2, {22'd0, note});
        wr(3'd3, div);
        wr(3'd5, dur);
        wr(3'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_drain"}, {31'd0, ok}, 32'd1);
        q.delete();
    endtask

    task automatic finish_note(input string name);
        drain(name);
        if (irq_en_m) begin
            check({name, "_irq_set"}, {31'd0, irq}, 32'd1);
            wr(3'd1, 32'd6);
            check({name, "_irq_clr"}, {31'd0, irq}, 32'd0);
        end else begin
            repeat (6) @(posedge clk);
            #1;
            check({name, "_irq_off"}, {31'd0, irq}, 32'd0);
            rd_check({name, "_status_done"}, 3'd1, 32'd2);
            wr(3'd1, 32'd2);
            rd_check({name, "_status_clr"}, 3'd1, 32'd0);
        end
    endtask

    task automatic take(input string name, input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = mk(-1, 0, 0, 0, 1'b0);
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_event: got an event, required none pending", name);
        end else begin
            e = q.pop_front();
            check({name, "_kind"}, e.kind, kind);
            ok = (e.kind == kind);
        end
    endtask

    initial begin : monitor
        logic        prev_pulse, prev_en, prev_irq, ok;
        logic [31:0] last_rise, play_start, play_sel, play_div;
        ev_t e;
        prev_pulse = 1'b0; prev_en = 1'b1; prev_irq = 1'b0;
        last_rise = 0; play_start = 0; play_sel = 0; play_div = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (noise_pulse === 1'b1 && prev_pulse === 1'b0) begin
                    take("pulse", EV_PULSE, e, ok);
                    if (ok) begin
                        check("pulse_noise", {16'd0, noise}, e.a);
                        check("pulse_noise_en", {31'd0, noise_en}, 32'd1);
                        if (!e.first) check("pulse_gap", cyc - last_rise, 2 * PH);
                    end
                    last_rise = cyc;
                end
                if (noise_en === 1'b0 && prev_en === 1'b1) begin
                    play_start = cyc;
                    play_sel   = {22'd0, sel_nota};
                    play_div   = div_freq;
                end
                if (noise_en === 1'b1 && prev_en === 1'b0) begin
                    take("play", EV_PLAY, e, ok);
                    if (ok) begin
                        check("play_sel_nota", play_sel, e.a);
                        check("play_div_freq", play_div, e.b);
                        if (e.c != DONT_CARE) check("play_len", cyc - play_start, e.c);
                    end
                end
                if (irq === 1'b1 && prev_irq === 1'b0) begin
                    take("done", EV_DONE, e, ok);
                end
            end
            prev_pulse = noise_pulse;
            prev_en    = noise_en;
            prev_irq   = irq;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        bit          ok;
        logic [15:0] seed;
        logic [9:0]  note;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_noise", {16'd0, noise}, 32'd0);
        check("rst_noise_en", {31'd0, noise_en}, 32'd1);
        check("rst_pulse", {31'd0, noise_pulse}, 32'd0);
        check("rst_sel_nota", {22'd0, sel_nota}, DEPTH - 1);
        check("rst_div_freq", div_freq, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd_check("rst_reg", a[2:0], 32'd0);

        // Register readback with width masking.
        d = $urandom; wr(3'd2, d); rd_check("note_rb", 3'd2, d & 32'h3FF);
        d = $urandom; wr(3'd3, d); rd_check("div_rb", 3'd3, d);
        d = $urandom; wr(3'd4, d); rd_check("seed_rb", 3'd4, d & 32'hFFFF);
        d = $urandom; wr(3'd5, d); rd_check("dur_rb", 3'd5, d);
        d = $urandom; wr(3'd6, d); rd_check("amp_rb", 3'd6, d & 32'hF);
        wr(3'd7, 32'hFFFF_FFFF); rd_check("addr7_zero", 3'd7, 32'd0);
        rd_check("ctrl_zero", 3'd0, 32'd0);

        // Basic pluck without interrupts; restart and config write mid-fill.
        pluck(16'd1, 4'd0, 10'd5, 32'd10, 32'd20, 1'b1);
        repeat (6) @(posedge clk);
        wr(3'd0, 32'd1);
        wr(3'd2, 32'd3);
        rd_check("status_busy", 3'd1, 32'd1);
        finish_note("basic");

        // Interrupt enabled from here on.
        wr(3'd1, 32'd4);
        irq_en_m = 1'b1;
        rd_check("status_irq_en", 3'd1, 32'd4);
        pluck(16'd1, 4'd0, 10'd5, 32'd10, 32'd20, 1'b1);
        finish_note("irq");

        pluck(16'h00FF, 4'd2, 10'd600, 32'd99, 32'd0, 1'b1);
        finish_note("clamp_dur0");

        pluck(16'd0, 4'd4, 10'd7, 32'h8000_0001, 32'd3, 1'b1);
        finish_note("seed0_amp4");

        // Abort during PLAY, abort during MUTE ignored, start+abort in IDLE.
        pluck(16'h1234, 4'd1, 10'd3, 32'd77, 32'd30, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (noise_en === 1'b0) begin ok = 1'b1; break; end
        end
        check("wait_play", {31'd0, ok}, 32'd1);
        wr(3'd0, 32'd2);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (q.size() <= 5) begin ok = 1'b1; break; end
        end
        check("wait_mute", {31'd0, ok}, 32'd1);
        wr(3'd0, 32'd2);
        finish_note("abort");
        wr(3'd0, 32'd3);
        repeat (20) @(posedge clk);
        rd_check("start_abort_idle", 3'd1, 32'd4);

        // Randomized plucks.
        for (int n = 0; n < 12; n++) begin
            seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            note = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
            pluck(seed, 4'($urandom), note, $urandom, 32'($urandom_range(0, 40)), 1'b1);
            finish_note("rand");
        end

        // Reset in the middle of a fill high phase.
        pluck(16'hBEEF, 4'd0, 10'd2, 32'd5, 32'd10, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (noise_pulse === 1'b1) begin ok = 1'b1; break; end
        end
        check("wait_fill_hi", {31'd0, ok}, 32'd1);
        q.delete();
        reset = 1'b1;
        irq_en_m = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pulse", {31'd0, noise_pulse}, 32'd0);
        check("mid_rst_noise_en", {31'd0, noise_en}, 32'd1);
        check("mid_rst_noise", {16'd0, noise}, 32'd0);
        check("mid_rst_sel", {22'd0, sel_nota}, DEPTH - 1);
        reset = 1'b0;
        for (int a = 1; a < 7; a++) rd_check("mid_rst_reg", a[2:0], 32'd0);
        repeat (40) @(posedge clk);
        check("mid_rst_quiet", {31'd0, noise_pulse}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/karplus_pluck_sequencer.md
Name: karplus_pluck_sequencer

Overview:
- Avalon-MM slave controller that sequences one "pluck" of the Karplus-Strong string-synthesis core.
- Drives the core's noise, noise_en, sel_nota, noise_pulse and div_freq inputs directly.
- Sequence: fill the delay line with LFSR noise, release it to play for a programmed duration, then mute by filling with zeros. Raises an interrupt when the note completes.
- Sits between the Nios Avalon bus and the synth core, so software issues one start write per note.

Parameters:
- DEPTH, 500: delay-line length of the synth core; number of fill pulses per fill phase.
- PULSE_HALF, 2: clk cycles per half-period of noise_pulse (high time = low time).
- LFSR_POLY, 16'hB400: Galois taps for the 16-bit noise LFSR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  3  Avalon register address
- chipselect  in  1  Avalon chip select
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero wait states
- irq  out  1  done interrupt
- noise  out  16  fill sample to synth core
- noise_en  out  1  1 = core in fill mode (core output silent)
- noise_pulse  out  1  fill shift clock to core
- sel_nota  out  10  delay tap select to core
- div_freq  out  32  playback divider to core

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Register map (wr_en = chipselect & write):
  - 0 CTRL (W): bit0 start, bit1 abort.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 irq_en. Writing bit1=1 clears done; writing bit2 sets irq_en.
  - 2 NOTE (R/W): 10 bits.
  - 3 DIV (R/W): 32 bits.
  - 4 SEED (R/W): 16 bits.
  - 5 DUR (R/W): 32 bits, sustain length in clk cycles.
  - 6 AMP (R/W): 4 bits, right-shift applied to noise.
  - 7: reads 0.
- Register semantics:
  - Config registers are writable at any time.
  - Working copies (note, div, dur, amp) are latched only on an accepted start.
- Reset values:
  - noise=0, noise_en=1, noise_pulse=0, sel_nota=DEPTH-1, div_freq=0, irq=0.
  - All registers 0, state IDLE, lfsr=16'hACE1.
- States: IDLE, FILL_LO, FILL_HI, PLAY, MUTE_LO, MUTE_HI, DONE.
- IDLE:
  - Outputs: noise_en=1, noise=0, noise_pulse=0.
  - On start write (abort bit clear): latch working copies and load lfsr from SEED (SEED==0 → 16'hACE1).
  - Clear fill_cnt, then go to FILL_LO.
- FILL_LO:
  - noise = lfsr >> amp, noise_pulse=0, held PULSE_HALF cycles.
  - Then go to FILL_HI.
- FILL_HI:
  - noise_pulse=1, held PULSE_HALF cycles. noise is stable for the whole period.
  - On exit: lfsr advances one step and fill_cnt increments.
  - fill_cnt==DEPTH → PLAY, else FILL_LO.
- PLAY:
  - noise_en=0; sel_nota = latched note, clamped to DEPTH-1 if ≥DEPTH; div_freq = latched div.
  - A dur_cnt counts clk cycles; at dur_cnt==dur go to MUTE_LO.
  - dur==0 → MUTE_LO on the next cycle.
- MUTE_LO / MUTE_HI:
  - Same timing as the fill states, with noise=0 and noise_en=1, for DEPTH pulses.
  - Then go to DONE.
- DONE: set done=1 for one cycle, then go to IDLE.
- Status and interrupt:
  - busy=1 in every state except IDLE.
  - irq = done & irq_en; done stays set until software clears it.
- Boundary conditions:
  - Start while busy: ignored.
  - Abort while FILL_* or PLAY: go to MUTE_LO with fill_cnt cleared; done is still set at completion.
  - Abort while MUTE_* or DONE: ignored.
  - Start and abort in the same write: abort wins; in IDLE this is a no-op.
  - Done-clear coinciding with DONE→IDLE: the set wins.
- Output rules:
  - All core-facing outputs are registered.
  - noise_pulse only changes at the FILL/MUTE half-period boundaries; no glitches, because the core uses it as a clock.
- LFSR step: lfsr = lfsr[0] ? (lfsr>>1) ^ LFSR_POLY : lfsr>>1.
- Counter widths: fill_cnt is $clog2(DEPTH+1) bits; dur_cnt is 32 bits, no wrap (terminal compare).

Decomposition:
- Package karplus_pkg:
  - Register address localparams.
  - State enum.
  - LFSR_POLY and LFSR_DEFAULT_SEED constants.
- Sub-module lfsr16: load/step enables, 16-bit state out.

Test Plan:
- DEPTH=8, PULSE_HALF=2. Write SEED=1, AMP=0, NOTE=5, DIV=10, DUR=20, then CTRL=1 → exactly 8 noise_pulse rising edges, each 4 clk apart. noise sequence 0x0001, 0xB400, 0x5A00, ...; noise_en falls after the 8th pulse; sel_nota=5, div_freq=10.
- Same setup: PLAY lasts 20 cycles, then 8 pulses with noise=0, then done=1. irq=1 only if STATUS bit2 was written; writing STATUS bit1=1 → irq=0.
- NOTE=600, DEPTH=8 → sel_nota=7 in PLAY. DUR=0 → PLAY lasts 1 cycle.
- CTRL=1 written again mid-fill → ignored (pulse count stays 8). CTRL=2 during PLAY → immediate mute fill of 8 zero pulses, then done.
- reset asserted mid-FILL_HI → next cycle: noise_pulse=0, noise_en=1, busy=0, all registers 0.
- SEED=0 → first noise=0xACE1. AMP=4 → first noise=0x0ACE.
